// File: rtl/divider.sv
// Sequential restoring divider for MIPS div/divu: one quotient bit per cycle,
// sign fix-up in a final cycle, fixed 33-cycle latency from acceptance to done.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_sign,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t r_state;
  state_t w_next;

  logic             r_sign;
  logic             r_zero;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_orig;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_hi;
  logic             r_dz;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_mag_a = (i_sign & i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
  assign w_mag_b = (i_sign & i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

  // Partial remainder stays below the divisor, so the shifted value fits 33 bits
  // and bit WIDTH of the difference is a reliable borrow.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_qbit  = ~w_diff[WIDTH];

  assign w_q_fix = (r_sign & (r_a_msb ^ r_b_msb)) ? -r_dvd : r_dvd;
  assign w_r_fix = (r_sign & r_a_msb) ? -r_rem : r_rem;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_orig  <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_hi    <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sign  <= i_sign;
            r_zero  <= (i_divisor == '0);
            r_a_msb <= i_dividend[WIDTH-1];
            r_b_msb <= i_divisor[WIDTH-1];
            r_orig  <= i_dividend;
            r_dvd   <= w_mag_a;
            r_dvs   <= w_mag_b;
            r_rem   <= '0;
            r_cnt   <= CW'(WIDTH - 1);
          end
        end
        S_RUN: begin
          r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_done <= 1'b1;
          r_dz   <= r_zero;
          r_quot <= r_zero ? '1 : w_q_fix;
          r_hi   <= r_zero ? r_orig : w_r_fix;
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_hi;
  assign o_div_by_zero = r_dz;

endmodule

// File: tb/tb_divider.sv
// Bench for divider: cycle-level reference model compared on every negedge,
// plus directed cases with literal expected results.
module tb_divider;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_sign;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_done = 0;
  bit chk_en = 1'b0;

  divider #(.WIDTH(32)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_sign        (i_sign),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: plain arithmetic. longint division truncates toward zero and the
  // remainder takes the dividend's sign; the overflow case wraps to 0x80000000.
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
    longint sa, sb;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Model state: an accepted op completes 33 edges later.
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  int          m_cnt    = 0;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic        m_dz = 1'b0, p_dz = 1'b0;

  always @(posedge i_clk) begin
    cyc++;
    if (i_reset) begin
      m_active = 1'b0; m_done = 1'b0;
      m_q = '0; m_r = '0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_cnt++;
        if (m_cnt == 33) begin
          m_active = 1'b0; m_done = 1'b1;
          m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (i_start) begin
        m_active = 1'b1;
        m_cnt    = 0;
        ref_div(i_sign, i_dividend, i_divisor, p_q, p_r, p_dz);
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("busy", 32'(o_busy), 32'(m_active));
      chk("done", 32'(o_done), 32'(m_done));
      chk("quotient", o_quotient, m_q);
      chk("remainder", o_remainder, m_r);
      chk("div_by_zero", 32'(o_div_by_zero), 32'(m_dz));
      if (o_done) n_done++;
    end
  end

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'h1;
      5:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input bit edz,
                        input string nm);
    int  busy_cnt;
    bit  got;
    @(negedge i_clk);
    i_start = 1'b1; i_sign = s; i_dividend = a; i_divisor = b;
    @(negedge i_clk);
    i_start = 1'b0; i_sign = ~s; i_dividend = $urandom; i_divisor = $urandom;
    busy_cnt = 0; got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (o_done) begin got = 1'b1; break; end
      if (o_busy) busy_cnt++;
      @(negedge i_clk);
    end
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'd33);
    chk({nm, " q"}, o_quotient, eq);
    chk({nm, " r"}, o_remainder, er);
    chk({nm, " dz"}, 32'(o_div_by_zero), 32'(edz));
  endtask

  int t1, t2, nd;
  bit got1, got2;

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_sign = 1'b0; i_dividend = '0; i_divisor = '0;
    @(negedge i_clk);
    chk_en = 1'b1;
    @(negedge i_clk);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset q", o_quotient, 32'd0);
    chk("reset r", o_remainder, 32'd0);
    i_reset = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "u100/7");
    run_op(1'b1, -32'd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "s-7/2");
    run_op(1'b1, 32'd7, -32'd2, 32'hFFFF_FFFD, 32'd1, 1'b0, "s7/-2");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, "uFFFFFFFF/1");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, "s_ovf");
    run_op(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, "s_dz");
    run_op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, "u_dz");

    // Abort 50/5 with reset on E10.
    @(negedge i_clk);
    i_start = 1'b1; i_sign = 1'b0; i_dividend = 32'd50; i_divisor = 32'd5;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (9) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("abort busy", 32'(o_busy), 32'd0);
    chk("abort q", o_quotient, 32'd0);
    chk("abort r", o_remainder, 32'd0);
    chk("abort dz", 32'(o_div_by_zero), 32'd0);
    nd = n_done;
    repeat (40) @(negedge i_clk);
    chk("abort no_done", 32'(n_done - nd), 32'd0);
    run_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, "u9/4");

    // Start held high: 20/3 then 21/3 accepted in the done cycle.
    @(negedge i_clk);
    i_start = 1'b1; i_sign = 1'b0; i_dividend = 32'd20; i_divisor = 32'd3;
    @(negedge i_clk);
    i_dividend = 32'd21;
    got1 = 1'b0; t1 = 0;
    for (int i = 0; i < 60; i++) begin
      if (o_done) begin got1 = 1'b1; t1 = cyc; break; end
      @(negedge i_clk);
    end
    chk("b2b first_done", 32'(got1), 32'd1);
    chk("b2b q1", o_quotient, 32'd6);
    chk("b2b r1", o_remainder, 32'd2);
    @(negedge i_clk);
    i_start = 1'b0; i_dividend = $urandom; i_divisor = $urandom;
    chk("b2b busy_after_done", 32'(o_busy), 32'd1);
    got2 = 1'b0; t2 = 0;
    for (int i = 0; i < 60; i++) begin
      if (o_done) begin got2 = 1'b1; t2 = cyc; break; end
      @(negedge i_clk);
    end
    chk("b2b second_done", 32'(got2), 32'd1);
    chk("b2b q2", o_quotient, 32'd7);
    chk("b2b r2", o_remainder, 32'd0);
    chk("b2b spacing", 32'(t2 - t1), 32'd34);

    // Random traffic: starts while busy, operand churn, occasional reset.
    nd = n_done;
    for (int c = 0; c < 8000; c++) begin
      @(negedge i_clk);
      i_start    = ($urandom_range(0, 3) == 0);
      i_sign     = 1'($urandom);
      i_dividend = rnd_op();
      i_divisor  = rnd_op();
      i_reset    = ($urandom_range(0, 299) == 0);
    end
    @(negedge i_clk);
    i_reset = 1'b0; i_start = 1'b0;
    repeat (40) @(negedge i_clk);
    checks++;
    if (n_done - nd < 100) begin
      errors++;
      $display("FAIL random_done_count: got %0d expected at least 100", n_done - nd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential 32-bit integer divider serving the MIPS `div`/`divu` instructions. It is the inverse companion of the shift-add multiplier step unit. It accepts a dividend/divisor pair with a start pulse and runs restoring division one quotient bit per cycle. It returns quotient (LO) and remainder (HI) with a one-cycle done pulse. The pipeline's HI/LO stage stalls on `busy`.

## Interface

Parameters:
- `WIDTH`, 32: operand and result width; all rules below are stated for 32.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `sign`  in  1  1 = signed (`div`), 0 = unsigned (`divu`); sampled with `start`.
- `dividend`  in  32  numerator; sampled with `start`.
- `divisor`  in  32  denominator; sampled with `start`.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; results valid.
- `quotient`  out  32  LO result; holds until the next completion.
- `remainder`  out  32  HI result; holds until the next completion.
- `div_by_zero`  out  1  flag for the last completed operation; holds with the results.

## Operation

- States are IDLE, RUN, FIX. Reset forces IDLE and clears `busy`, `done`, `quotient`, `remainder` and `div_by_zero` to 0.
- IDLE with `start`=1:
  - Latch `sign`, the divisor-zero flag, both operand signs and both magnitudes. In signed mode a magnitude is the two's-complement negation when bit 31 is set; in unsigned mode it is the raw operand.
  - Clear the 33-bit partial remainder.
  - Load the 5-bit iteration counter with 31.
  - Go to RUN.
- RUN, once per cycle:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor magnitude using a 33-bit subtract.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - At counter 0 go to FIX; otherwise decrement the counter.
- FIX, one cycle:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative; the remainder always takes the dividend's sign.
  - Register the outputs, pulse `done`, return to IDLE.
- Divide by zero (divisor == 0 at start):
  - Latency is unchanged.
  - FIX forces `quotient`=32'hFFFFFFFF, `remainder`=`dividend` (the original operand) and `div_by_zero`=1.
  - Otherwise `div_by_zero`=0.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0, `div_by_zero`=0. No trap is raised.
- `start` while busy is ignored. Operands and `sign` may change freely after the accepting edge.

## Timing

- The accepting edge is E0. RUN spans edges E1..E32. FIX executes on E33.
- `busy`=1 in the cycles after E0 through E32; it is 0 after E33.
- `done`=1 for exactly the one cycle after E33. `quotient`, `remainder` and `div_by_zero` update on E33.
- Fixed latency: 33 cycles from acceptance to done, for every operand pair including zero divisor.
- `start` asserted during the `done` cycle is accepted, since the state is IDLE; `done` and `busy` are then both 0 and 1 respectively in the next cycle. Back-to-back throughput is one result per 34 cycles.
- `reset` at any edge, including mid-RUN and the FIX edge, wins over all other activity:
  - The next cycle is IDLE with all outputs 0.
  - No `done` is produced for the aborted operation.
- `reset` and `start` on the same edge: reset wins and the start is dropped.

## Test plan

- Unsigned 100 / 7 (`sign`=0):
  - `done` one cycle after E33, with quotient=14, remainder=2, `div_by_zero`=0.
  - `busy` high exactly 33 cycles.
- Signed -7 / 2 and 7 / -2:
  - -7 / 2 gives quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 7 / -2 gives quotient=0xFFFFFFFD, remainder=1.
  - Unsigned 0xFFFFFFFF / 1 gives quotient=0xFFFFFFFF, remainder=0.
- Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, `div_by_zero`=0.
- Divisor 0 with dividend 0x12345678 (both modes): after 33 cycles, quotient=0xFFFFFFFF, remainder=0x12345678, `div_by_zero`=1.
- Reset mid-operation:
  - Start 50 / 5, assert `reset` on E10: `busy`=0, `done` never pulses, outputs are 0.
  - Start 9 / 4 afterwards: quotient=2, remainder=1 at E33 of the new operation.
- Back-to-back and ignored start:
  - Hold `start`=1 continuously with 20 / 3 then 21 / 3: results come out 6 r 2, then 7 r 0, 34 cycles apart.
  - Operands changed while busy do not affect the in-flight result.
